// File: rtl/key_beep_pkg.sv
// key_beep_pkg: shared constants for the key/beep demo.
package key_beep_pkg;
  localparam int CNT_W = 20;
  localparam logic KEY_IDLE = 1'b1;
  localparam logic [CNT_W-1:0] CNT_MAX_50MHZ_20MS = 20'd999_999;
endpackage

// File: rtl/key_beep_if.sv
// key_beep_if: board pins of the demo, raw key in and buzzer enable out.
interface key_beep_if;
  logic key;
  logic beep;
  modport master (output key, input beep);
  modport slave (input key, output beep);
endinterface

// File: rtl/key_filter.sv
// key_filter: synchronizes and debounces an active-low key into a one-cycle press flag.
module key_filter
  import key_beep_pkg::*;
#(
  parameter logic [CNT_W-1:0] CNT_MAX = CNT_MAX_50MHZ_20MS
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic key,
  output logic key_flag
);
  logic key_s1_q, key_s1_d, key_s_q, key_s_d, key_flag_q, key_flag_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb begin
    key_s1_d   = key;
    key_s_d    = key_s1_q;
    // saturating at CNT_MAX keeps a held key from re-flagging
    cnt_d      = key_s_q ? '0 : (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    key_flag_d = !key_s_q && (cnt_q == CNT_MAX - 1'b1);
  end
  always_ff @(posedge sys_clk or posedge sys_rst)
    if (sys_rst) begin
      key_s1_q   <= KEY_IDLE;
      key_s_q    <= KEY_IDLE;
      cnt_q      <= '0;
      key_flag_q <= 1'b0;
    end else begin
      key_s1_q   <= key_s1_d;
      key_s_q    <= key_s_d;
      cnt_q      <= cnt_d;
      key_flag_q <= key_flag_d;
    end
  assign key_flag = key_flag_q;
endmodule

// File: rtl/key_beep_top.sv
// key_beep_top: toggles the buzzer enable once per debounced key press.
module key_beep_top
  import key_beep_pkg::*;
#(
  parameter logic [CNT_W-1:0] CNT_MAX = CNT_MAX_50MHZ_20MS
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  key_beep_if.slave  io
);
  logic key_flag, beep_q, beep_d;
  key_filter #(.CNT_MAX(CNT_MAX)) u_filt (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .key     (io.key),
    .key_flag(key_flag)
  );
  always_comb beep_d = beep_q ^ key_flag;
  always_ff @(posedge sys_clk or posedge sys_rst)
    if (sys_rst) beep_q <= 1'b0;
    else         beep_q <= beep_d;
  assign io.beep = beep_q;
endmodule

// File: tb/tb_key_beep_top.sv
// tb_key_beep_top: run-length reference model compared every cycle, plus directed literal checks.
module tb_key_beep_top;
  localparam logic [19:0] CM = 20'd10;
  localparam int CMI = 10;
  logic clk = 1'b0, rst = 1'b1;
  always #10 clk = ~clk;
  key_beep_if bus();
  key_beep_top #(.CNT_MAX(CM)) dut (.sys_clk(clk), .sys_rst(rst), .io(bus));
  int vecs = 0, errs = 0;
  task automatic chk(input string nm, input int a, input int e);
    vecs++;
    if (a != e) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, a, e, $time);
    end
  endtask
  // model: key samples arrive two edges late; a press is the CM-th consecutive low sample
  bit m_s1 = 1'b1, m_s2 = 1'b1, m_flag = 1'b0, m_beep = 1'b0;
  int m_run = 0;
  function automatic int nxt_run(input bit s, input int r);
    return s ? 0 : (r > CMI ? r : r + 1);
  endfunction
  always @(posedge clk)
    if (rst) begin
      m_s1 <= 1'b1; m_s2 <= 1'b1; m_run <= 0; m_flag <= 1'b0; m_beep <= 1'b0;
    end else begin
      m_beep <= m_beep ^ m_flag;
      m_run  <= nxt_run(m_s2, m_run);
      m_flag <= (nxt_run(m_s2, m_run) == CMI);
      m_s2   <= m_s1;
      m_s1   <= bus.key;
    end
  always @(negedge clk) begin
    chk("beep", int'(bus.beep), rst ? 0 : int'(m_beep));
    chk("key_flag", int'(dut.u_filt.key_flag), rst ? 0 : int'(m_flag));
  end
  initial begin
    int lat, flags;
    bus.key = 1'b1;
    #200 rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("t1_beep_after_reset", int'(bus.beep), 0);
    bus.key = 1'b0;
    repeat (2) @(negedge clk);
    bus.key = 1'b1;
    flags = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      flags += int'(dut.u_filt.key_flag);
    end
    chk("t2_short_flags", flags, 0);
    chk("t2_short_beep", int'(bus.beep), 0);
    bus.key = 1'b0;
    lat = -1;
    flags = 0;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      if (bus.beep && lat < 0) lat = i - 1;
      flags += int'(dut.u_filt.key_flag);
    end
    chk("t3_latency_edges", lat, 12);
    chk("t3_flag_pulses", flags, 1);
    chk("t3_beep_held", int'(bus.beep), 1);
    bus.key = 1'b1;
    #45 bus.key = 1'b0;
    #40 bus.key = 1'b1;
    repeat (20) @(negedge clk);
    chk("t4_glitch_beep", int'(bus.beep), 1);
    bus.key = 1'b0;
    repeat (16) @(negedge clk);
    chk("t5_second_press", int'(bus.beep), 0);
    bus.key = 1'b1;
    repeat (5) @(negedge clk);
    bus.key = 1'b0;
    repeat (16) @(negedge clk);
    chk("t5_third_press", int'(bus.beep), 1);
    bus.key = 1'b1;
    repeat (5) @(negedge clk);
    bus.key = 1'b0;
    repeat (8) @(negedge clk);
    chk("t6_before_reset", int'(bus.beep), 1);
    #5 rst = 1'b1;
    #1 chk("t6_async_beep", int'(bus.beep), 0);
    chk("t6_async_flag", int'(dut.u_filt.key_flag), 0);
    @(negedge clk) rst = 1'b0;
    bus.key = 1'b1;
    repeat (3) @(negedge clk);
    bus.key = 1'b0;
    repeat (12) @(negedge clk);
    chk("t6_no_early_toggle", int'(bus.beep), 0);
    @(negedge clk);
    chk("t6_fresh_press", int'(bus.beep), 1);
    bus.key = 1'b1;
    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
